lcd_cmd_sequencer: RTL and testbench

- Sits directly upstream of the LCD instruction FSM on the Spartan 3E 4-bit LCD path.
- Runs the power-on nibble initialisation itself, driving SF_D and LCD_E through a downstream mux.
- Then issues the configuration commands (Function Set, Entry Mode, Display On, Clear) and character/command writes to the instruction FSM as 10-bit db words.
- Owns the per-instruction clk_cnt timebase that the instruction FSM decodes, and paces every transfer on that FSM's busy.

---
 rtl/lcd_cmd_sequencer_if.sv | 27 ++
 rtl/lcd_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_sequencer_if.sv
// rtl/lcd_cmd_sequencer_if.sv - user write, instruction FSM and init-mux signals of the LCD sequencer
interface lcd_cmd_sequencer_if;
  logic       char_valid;
  logic       char_rs;
  logic [7:0] char_data;
  logic       char_ready;
  logic       busy;
  logic       next_instruction;
  logic [9:0] db;
  logic [11:0] clk_cnt;
  logic       init_active;
  logic [3:0] init_sf_d;
  logic       init_lcd_e;
  logic       init_done;

  modport master (
    input  char_valid, char_rs, char_data, busy,
    output char_ready, next_instruction, db, clk_cnt,
           init_active, init_sf_d, init_lcd_e, init_done
  );

  modport slave (
    output char_valid, char_rs, char_data, busy,
    input  char_ready, next_instruction, db, clk_cnt,
           init_active, init_sf_d, init_lcd_e, init_done
  );
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// rtl/lcd_cmd_sequencer.sv - power-on nibble init, config commands and user writes for the 4-bit LCD path
module lcd_cmd_sequencer #(
  parameter int T_POWERON = 750000,
  parameter int T_GAP1    = 205000,
  parameter int T_GAP2    = 5000,
  parameter int T_GAP3    = 2000,
  parameter int T_E       = 12,
  parameter int T_CLEAR   = 82000
) (
  input  logic clk,
  input  logic reset,
  lcd_cmd_sequencer_if.master bus
);

  localparam logic [3:0] PWR_WAIT   = 4'd0;
  localparam logic [3:0] INIT_SETUP = 4'd1;
  localparam logic [3:0] INIT_PULSE = 4'd2;
  localparam logic [3:0] INIT_HOLD  = 4'd3;
  localparam logic [3:0] INIT_GAP   = 4'd4;
  localparam logic [3:0] CFG_ISSUE  = 4'd5;
  localparam logic [3:0] WAIT_HI    = 4'd6;
  localparam logic [3:0] WAIT_LO    = 4'd7;
  localparam logic [3:0] CLR_WAIT   = 4'd8;
  localparam logic [3:0] READY      = 4'd9;
  localparam logic [3:0] USR_ISSUE  = 4'd10;

  localparam logic [19:0] W_PWR  = 20'(T_POWERON - 1);
  localparam logic [19:0] W_G1   = 20'(T_GAP1 - 1);
  localparam logic [19:0] W_G2   = 20'(T_GAP2 - 1);
  localparam logic [19:0] W_G3   = 20'(T_GAP3 - 1);
  localparam logic [19:0] W_E    = 20'(T_E - 1);
  localparam logic [19:0] W_CLR  = 20'(T_CLEAR - 1);

  function automatic logic [19:0] gap_last(input logic [1:0] idx);
    case (idx)
      2'd0:    gap_last = W_G1;
      2'd1:    gap_last = W_G2;
      default: gap_last = W_G3;
    endcase
  endfunction

  function automatic logic [3:0] nibble(input logic [1:0] idx);
    nibble = (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  function automatic logic [9:0] cfg_word(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_word = 10'h028;
      2'd1:    cfg_word = 10'h006;
      2'd2:    cfg_word = 10'h00C;
      default: cfg_word = 10'h001;
    endcase
  endfunction

  logic [3:0]  state, state_next;
  logic [19:0] wait_cnt;
  logic [1:0]  k, k_nxt;
  logic [1:0]  j, j_nxt;
  logic        is_clr;
  logic        half_tick;

  logic        next_instruction_q;
  logic [9:0]  db_q;
  logic [11:0] clk_cnt_q;
  logic        char_ready_q;
  logic        init_active_q;
  logic [3:0]  init_sf_d_q;
  logic        init_lcd_e_q;
  logic        init_done_q;

  assign bus.next_instruction = next_instruction_q;
  assign bus.db               = db_q;
  assign bus.clk_cnt          = clk_cnt_q;
  assign bus.char_ready       = char_ready_q;
  assign bus.init_active      = init_active_q;
  assign bus.init_sf_d        = init_sf_d_q;
  assign bus.init_lcd_e       = init_lcd_e_q;
  assign bus.init_done        = init_done_q;

  assign k_nxt = (state == INIT_GAP) ? k + 2'd1 : 2'd0;
  assign j_nxt = (state == WAIT_LO)  ? j + 2'd1 : 2'd0;

  always_comb begin
    state_next = state;
    case (state)
      PWR_WAIT:   if (wait_cnt == W_PWR) state_next = INIT_SETUP;
      INIT_SETUP: if (wait_cnt == 20'd1) state_next = INIT_PULSE;
      INIT_PULSE: if (wait_cnt == W_E) state_next = INIT_HOLD;
      INIT_HOLD:  state_next = INIT_GAP;
      INIT_GAP:   if (wait_cnt == gap_last(k)) state_next = (k == 2'd3) ? CFG_ISSUE : INIT_SETUP;
      CFG_ISSUE,
      USR_ISSUE:  state_next = WAIT_HI;
      WAIT_HI:    if (bus.busy) state_next = WAIT_LO;
      WAIT_LO: begin
        // init_done separates user traffic from the configuration pass
        if (!bus.busy) begin
          if (init_done_q)     state_next = is_clr ? CLR_WAIT : READY;
          else if (j == 2'd3)  state_next = CLR_WAIT;
          else                 state_next = CFG_ISSUE;
        end
      end
      CLR_WAIT:   if (wait_cnt == W_CLR) state_next = READY;
      READY:      if (bus.char_valid && char_ready_q) state_next = USR_ISSUE;
      default:    state_next = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= PWR_WAIT;
      wait_cnt           <= 20'd0;
      k                  <= 2'd0;
      j                  <= 2'd0;
      is_clr             <= 1'b0;
      half_tick          <= 1'b0;
      next_instruction_q <= 1'b0;
      db_q               <= 10'd0;
      clk_cnt_q          <= 12'd0;
      char_ready_q       <= 1'b0;
      init_active_q      <= 1'b1;
      init_sf_d_q        <= 4'd0;
      init_lcd_e_q       <= 1'b0;
      init_done_q        <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state_next != state) ? 20'd0 : wait_cnt + 20'd1;

      next_instruction_q <= (state_next == CFG_ISSUE) || (state_next == USR_ISSUE);
      char_ready_q       <= (state_next == READY);
      init_lcd_e_q       <= (state_next == INIT_PULSE);

      if (state_next == INIT_SETUP && state != INIT_SETUP) begin
        init_sf_d_q <= nibble(k_nxt);
        k           <= k_nxt;
      end

      if (state == INIT_GAP && state_next == CFG_ISSUE) begin
        init_active_q <= 1'b0;
        init_sf_d_q   <= 4'd0;
      end

      if (state_next == CFG_ISSUE) begin
        db_q <= cfg_word(j_nxt);
        j    <= j_nxt;
      end

      if (state_next == USR_ISSUE) begin
        db_q   <= {bus.char_rs, 1'b0, bus.char_data};
        is_clr <= !bus.char_rs && (bus.char_data == 8'h01 || bus.char_data == 8'h02 ||
                                   bus.char_data == 8'h03);
      end

      // ISSUE states last one cycle, so this fires exactly with the start pulse
      if (state_next == CFG_ISSUE || state_next == USR_ISSUE) begin
        clk_cnt_q <= 12'd0;
        half_tick <= 1'b0;
      end else begin
        half_tick <= ~half_tick;
        if (half_tick && clk_cnt_q != 12'hFFF) clk_cnt_q <= clk_cnt_q + 12'd1;
      end

      if (state == CLR_WAIT && state_next == READY) init_done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb/tb_lcd_cmd_sequencer.sv - randomized self-checking bench for lcd_cmd_sequencer
module tb_lcd_cmd_sequencer;
  localparam int TP = 100, G1 = 50, G2 = 20, G3 = 10, TE = 12, TC = 40, BUSY_HI = 2082;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  lcd_cmd_sequencer_if bus_if();

  lcd_cmd_sequencer #(
    .T_POWERON(TP), .T_GAP1(G1), .T_GAP2(G2), .T_GAP3(G3), .T_E(TE), .T_CLEAR(TC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Instruction FSM stand-in: busy rises 2 cycles after the start pulse for BUSY_HI cycles
  initial begin
    bus_if.busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.next_instruction === 1'b1) begin
        repeat (2) @(posedge clk);
        #1 bus_if.busy = 1'b1;
        repeat (BUSY_HI) @(posedge clk);
        #1 bus_if.busy = 1'b0;
      end
    end
  end

  int          p_start[$], p_width[$], ni_cyc[$], fall_cyc[$], act_q[$], done_q[$], rdy_q[$], acc_cyc[$];
  logic [3:0]  p_nib[$];
  logic        p_ok[$];
  logic [9:0]  ni_db[$], acc_word[$];
  logic [11:0] ni_clk[$], hi_clk[$];
  logic        pe, pbusy, pact, pdone, prdy, nib_ok;
  logic [3:0]  cur_nib;
  logic [11:0] pclk;

  always @(negedge clk) begin
    if (reset) begin
      pe <= 1'b0; pbusy <= 1'b0; pact <= 1'b1; pdone <= 1'b0; prdy <= 1'b0; pclk <= 12'd0;
    end else begin
      if (bus_if.init_lcd_e && !pe) begin
        p_start.push_back(cyc); p_nib.push_back(bus_if.init_sf_d);
        cur_nib <= bus_if.init_sf_d; nib_ok <= 1'b1;
      end else if (bus_if.init_lcd_e && bus_if.init_sf_d != cur_nib) nib_ok <= 1'b0;
      if (!bus_if.init_lcd_e && pe) begin
        p_width.push_back(cyc - p_start[$]);
        p_ok.push_back(nib_ok && bus_if.init_sf_d == cur_nib);
      end
      if (bus_if.next_instruction) begin
        ni_cyc.push_back(cyc); ni_db.push_back(bus_if.db); ni_clk.push_back(bus_if.clk_cnt);
      end
      if (!bus_if.busy && pbusy) begin fall_cyc.push_back(cyc); hi_clk.push_back(pclk); end
      if (!bus_if.init_active && pact) act_q.push_back(cyc);
      if (bus_if.init_done && !pdone) done_q.push_back(cyc);
      if (bus_if.char_ready && !prdy) rdy_q.push_back(cyc);
      if (bus_if.char_ready && bus_if.char_valid) begin
        acc_cyc.push_back(cyc); acc_word.push_back({bus_if.char_rs, 1'b0, bus_if.char_data});
      end
      pe <= bus_if.init_lcd_e; pbusy <= bus_if.busy; pact <= bus_if.init_active;
      pdone <= bus_if.init_done; prdy <= bus_if.char_ready; pclk <= bus_if.clk_cnt;
    end
  end

  task automatic clear_logs();
    p_start.delete(); p_width.delete(); p_nib.delete(); p_ok.delete();
    ni_cyc.delete(); ni_db.delete(); ni_clk.delete(); fall_cyc.delete(); hi_clk.delete();
    act_q.delete(); done_q.delete(); rdy_q.delete(); acc_cyc.delete(); acc_word.delete();
  endtask

  function automatic int half_count(input int d);
    return (d / 2 > 4095) ? 4095 : d / 2;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (bus_if.next_instruction !== 1'b0) begin tests_failed++; $display("FAIL reset_ni got %b want 0", bus_if.next_instruction); end
    tests_run++; if (bus_if.db !== 10'd0) begin tests_failed++; $display("FAIL reset_db got %h want 000", bus_if.db); end
    tests_run++; if (bus_if.clk_cnt !== 12'd0) begin tests_failed++; $display("FAIL reset_clk_cnt got %0d want 0", bus_if.clk_cnt); end
    tests_run++; if (bus_if.char_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %b want 0", bus_if.char_ready); end
    tests_run++; if (bus_if.init_active !== 1'b1) begin tests_failed++; $display("FAIL reset_init_active got %b want 1", bus_if.init_active); end
    tests_run++; if (bus_if.init_sf_d !== 4'd0) begin tests_failed++; $display("FAIL reset_sf_d got %h want 0", bus_if.init_sf_d); end
    tests_run++; if (bus_if.init_lcd_e !== 1'b0) begin tests_failed++; $display("FAIL reset_lcd_e got %b want 0", bus_if.init_lcd_e); end
    tests_run++; if (bus_if.init_done !== 1'b0) begin tests_failed++; $display("FAIL reset_init_done got %b want 0", bus_if.init_done); end
    clear_logs();
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic test_init_sequence();
    int nib_tab[4] = '{3, 3, 3, 2};
    int gap_tab[4] = '{G1, G2, G3, G3};
    int s, s_end, n;
    n = 0;
    while (act_q.size() == 0 && n < 3000) begin @(negedge clk); n++; end
    tests_run++; if (n >= 3000) begin tests_failed++; $display("FAIL init_timeout waited %0d cycles for init_active fall", n); end
    tests_run++; if (p_start.size() != 4 || p_width.size() != 4) begin tests_failed++; $display("FAIL init_pulse_count got %0d want 4", p_start.size()); end
    s = TP + 2; s_end = 0;
    for (int i = 0; i < 4; i++) begin
      s_end = s + TE + 1 + gap_tab[i];
      if (i < p_start.size() && i < p_width.size()) begin
        tests_run++; if (p_start[i] != s) begin tests_failed++; $display("FAIL init_pulse%0d_start got %0d want %0d", i, p_start[i], s); end
        tests_run++; if (p_width[i] != TE) begin tests_failed++; $display("FAIL init_pulse%0d_width got %0d want %0d", i, p_width[i], TE); end
        tests_run++; if (p_nib[i] != 4'(nib_tab[i]) || !p_ok[i]) begin tests_failed++; $display("FAIL init_pulse%0d_nibble got %h stable %b want %0d", i, p_nib[i], p_ok[i], nib_tab[i]); end
      end
      s = s_end + 2;
    end
    tests_run++; if (act_q.size() != 1 || act_q[0] != s_end) begin tests_failed++; $display("FAIL init_active_fall got %0d want %0d", (act_q.size() > 0) ? act_q[0] : -1, s_end); end
  endtask

  task automatic test_config();
    logic [9:0] cfg_tab[4] = '{10'h028, 10'h006, 10'h00C, 10'h001};
    int n;
    n = 0;
    while (done_q.size() == 0 && n < 12000) begin @(negedge clk); n++; end
    tests_run++; if (n >= 12000) begin tests_failed++; $display("FAIL cfg_timeout waited %0d cycles for init_done", n); end
    tests_run++; if (ni_cyc.size() != 4 || fall_cyc.size() != 4) begin tests_failed++; $display("FAIL cfg_counts ni %0d falls %0d want 4 4", ni_cyc.size(), fall_cyc.size()); end
    if (ni_cyc.size() == 4 && fall_cyc.size() == 4 && act_q.size() == 1) begin
      tests_run++; if (ni_cyc[0] != act_q[0]) begin tests_failed++; $display("FAIL cfg_first_issue got %0d want %0d", ni_cyc[0], act_q[0]); end
      for (int i = 0; i < 4; i++) begin
        tests_run++; if (ni_db[i] !== cfg_tab[i]) begin tests_failed++; $display("FAIL cfg_db%0d got %h want %h", i, ni_db[i], cfg_tab[i]); end
        tests_run++; if (ni_clk[i] !== 12'd0) begin tests_failed++; $display("FAIL cfg_clk_cnt_clear%0d got %0d want 0", i, ni_clk[i]); end
        tests_run++; if (hi_clk[i] != 12'(half_count(fall_cyc[i] - 1 - ni_cyc[i]))) begin tests_failed++; $display("FAIL cfg_clk_cnt_busy%0d got %0d want %0d", i, hi_clk[i], half_count(fall_cyc[i] - 1 - ni_cyc[i])); end
        if (i < 3) begin
          tests_run++; if (ni_cyc[i + 1] != fall_cyc[i] + 1) begin tests_failed++; $display("FAIL cfg_spacing%0d got %0d want %0d", i, ni_cyc[i + 1], fall_cyc[i] + 1); end
        end
      end
      tests_run++; if (done_q[0] != fall_cyc[3] + 1 + TC) begin tests_failed++; $display("FAIL cfg_done_time got %0d want %0d", done_q[0], fall_cyc[3] + 1 + TC); end
      tests_run++; if (rdy_q.size() != 1 || rdy_q[0] != done_q[0]) begin tests_failed++; $display("FAIL cfg_ready_time got %0d want %0d", (rdy_q.size() > 0) ? rdy_q[0] : -1, done_q[0]); end
    end
  endtask

  task automatic test_char_write();
    for (int w = 0; w < 3; w++) begin
      logic r; logic [7:0] d; logic [9:0] word; int n;
      if (w == 0)      begin r = 1'b1; d = 8'h41; end
      else if (w == 1) begin r = 1'b1; d = 8'($urandom); end
      else             begin r = 1'b0; d = 8'h80 | 8'($urandom_range(0, 127)); end
      word = {r, 1'b0, d};
      n = 0;
      while (bus_if.char_ready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
      tests_run++; if (n >= 5000) begin tests_failed++; $display("FAIL char%0d_ready_timeout waited %0d", w, n); end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      clear_logs();
      @(posedge clk); #1;
      bus_if.char_valid = 1'b1; bus_if.char_rs = r; bus_if.char_data = d;
      @(posedge clk); #1;
      bus_if.char_valid = 1'b0; bus_if.char_rs = 1'($urandom); bus_if.char_data = 8'($urandom);
      tests_run++; if (bus_if.char_ready !== 1'b0) begin tests_failed++; $display("FAIL char%0d_ready_drop got %b want 0", w, bus_if.char_ready); end
      tests_run++; if (bus_if.next_instruction !== 1'b1 || bus_if.db !== word) begin tests_failed++; $display("FAIL char%0d_issue ni %b db %h want 1 %h", w, bus_if.next_instruction, bus_if.db, word); end
      tests_run++; if (bus_if.clk_cnt !== 12'd0) begin tests_failed++; $display("FAIL char%0d_clk_cnt_clear got %0d want 0", w, bus_if.clk_cnt); end
      n = 0;
      while (rdy_q.size() == 0 && n < 5000) begin @(negedge clk); n++; end
      tests_run++; if (n >= 5000 || fall_cyc.size() != 1 || ni_cyc.size() != 1) begin tests_failed++; $display("FAIL char%0d_complete falls %0d issues %0d want 1 1", w, fall_cyc.size(), ni_cyc.size()); end
      else begin
        tests_run++; if (hi_clk[0] != 12'(half_count(fall_cyc[0] - 1 - ni_cyc[0]))) begin tests_failed++; $display("FAIL char%0d_clk_cnt_busy got %0d want %0d", w, hi_clk[0], half_count(fall_cyc[0] - 1 - ni_cyc[0])); end
        tests_run++; if (rdy_q[0] != fall_cyc[0] + 1) begin tests_failed++; $display("FAIL char%0d_ready_return got %0d want %0d", w, rdy_q[0], fall_cyc[0] + 1); end
        tests_run++; if (bus_if.db !== word) begin tests_failed++; $display("FAIL char%0d_db_hold got %h want %h", w, bus_if.db, word); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_w[3];
    int n;
    exp_w[0] = 10'h242; exp_w[1] = 10'h243; exp_w[2] = {2'b10, 8'($urandom)};
    n = 0;
    while (bus_if.char_ready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    clear_logs();
    @(posedge clk); #1;
    bus_if.char_valid = 1'b1; bus_if.char_rs = 1'b1; bus_if.char_data = exp_w[0][7:0];
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (bus_if.char_ready !== 1'b1 && n < 6000);
      tests_run++; if (n >= 6000) begin tests_failed++; $display("FAIL b2b_accept%0d_timeout waited %0d", i, n); end
      @(posedge clk); #1;
      if (i < 2) bus_if.char_data = exp_w[i + 1][7:0];
      else       bus_if.char_valid = 1'b0;
    end
    n = 0;
    while (fall_cyc.size() < 3 && n < 8000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    tests_run++; if (acc_word.size() != 3 || ni_db.size() != 3 || fall_cyc.size() != 3) begin tests_failed++; $display("FAIL b2b_counts accepts %0d issues %0d falls %0d want 3 3 3", acc_word.size(), ni_db.size(), fall_cyc.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++; if (acc_word[i] !== exp_w[i] || ni_db[i] !== exp_w[i]) begin tests_failed++; $display("FAIL b2b_word%0d accepted %h issued %h want %h", i, acc_word[i], ni_db[i], exp_w[i]); end
        tests_run++; if (ni_cyc[i] != acc_cyc[i] + 1) begin tests_failed++; $display("FAIL b2b_issue%0d got %0d want %0d", i, ni_cyc[i], acc_cyc[i] + 1); end
        if (i < 2) begin
          tests_run++; if (acc_cyc[i + 1] != fall_cyc[i] + 1) begin tests_failed++; $display("FAIL b2b_pacing%0d got %0d want %0d", i, acc_cyc[i + 1], fall_cyc[i] + 1); end
        end
      end
    end
  endtask

  task automatic test_user_clear();
    logic [7:0] d; logic [9:0] word; int n;
    d = 8'($urandom_range(1, 3));
    word = {2'b00, d};
    n = 0;
    while (bus_if.char_ready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    clear_logs();
    @(posedge clk); #1;
    bus_if.char_valid = 1'b1; bus_if.char_rs = 1'b0; bus_if.char_data = d;
    @(posedge clk); #1;
    bus_if.char_valid = 1'b0; bus_if.char_data = 8'($urandom);
    tests_run++; if (bus_if.next_instruction !== 1'b1 || bus_if.db !== word) begin tests_failed++; $display("FAIL clr_issue ni %b db %h want 1 %h", bus_if.next_instruction, bus_if.db, word); end
    n = 0;
    while (rdy_q.size() == 0 && n < 5000) begin @(negedge clk); n++; end
    tests_run++; if (n >= 5000 || fall_cyc.size() != 1 || rdy_q[0] != fall_cyc[0] + 1 + TC) begin tests_failed++; $display("FAIL clr_ready_delay got %0d want %0d", (rdy_q.size() > 0) ? rdy_q[0] : -1, (fall_cyc.size() > 0) ? fall_cyc[0] + 1 + TC : -1); end
    tests_run++; if (bus_if.init_done !== 1'b1 || done_q.size() != 0) begin tests_failed++; $display("FAIL clr_init_done got %b rises %0d want 1 0", bus_if.init_done, done_q.size()); end
  endtask

  task automatic test_midop_reset();
    int n;
    @(posedge clk); #3 reset = 1'b1;
    repeat (3) @(posedge clk);
    clear_logs();
    @(negedge clk); #2 reset = 1'b0;
    n = 0;
    while (p_start.size() < 2 && n < 1000) begin @(negedge clk); n++; end
    tests_run++; if (n >= 1000) begin tests_failed++; $display("FAIL midop_second_pulse_timeout waited %0d", n); end
    repeat (4) @(posedge clk);
    #1;
    tests_run++; if (bus_if.init_lcd_e !== 1'b1) begin tests_failed++; $display("FAIL midop_in_pulse got lcd_e %b want 1", bus_if.init_lcd_e); end
    #2 reset = 1'b1;
    #1;
    tests_run++; if (bus_if.init_lcd_e !== 1'b0 || bus_if.init_active !== 1'b1) begin tests_failed++; $display("FAIL midop_async lcd_e %b active %b want 0 1", bus_if.init_lcd_e, bus_if.init_active); end
    tests_run++; if (bus_if.init_sf_d !== 4'd0 || bus_if.db !== 10'd0 || bus_if.clk_cnt !== 12'd0 || bus_if.init_done !== 1'b0 || bus_if.char_ready !== 1'b0) begin tests_failed++; $display("FAIL midop_outputs sf_d %h db %h clk_cnt %0d done %b ready %b want all 0", bus_if.init_sf_d, bus_if.db, bus_if.clk_cnt, bus_if.init_done, bus_if.char_ready); end
    repeat (3) @(posedge clk);
    clear_logs();
    @(negedge clk); #2 reset = 1'b0;
    test_init_sequence();
  endtask

  initial begin
    bus_if.char_valid = 1'b0;
    bus_if.char_rs    = 1'b0;
    bus_if.char_data  = 8'd0;
    test_reset();
    test_init_sequence();
    test_config();
    test_char_write();
    test_back_to_back();
    test_user_clear();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
